operand_stack: RTL

- Operand stack for the bytecode datapath; sits directly upstream of the integer ALU and feeds it.
- Top two entries are held in registers and drive the ALU operands (`operand_a` = next-on-stack NOS, `operand_b` = top-of-stack TOS), which matches JVM value1/value2 ordering.
- Deeper entries live in a synchronous-read spill RAM.
- The execute stage issues one stack command per handshake; the ALU result is written back in the same cycle as the BINOP/UNOP command.

---
 rtl/stack_pkg.sv | 23 ++
 rtl/stack_ram.sv | 31 +++
 rtl/operand_stack.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the operand stack that feeds the integer ALU.
package stack_pkg;

    localparam int STACK_WIDTH = 32;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_PUSH  = 3'b001,
        OP_POP   = 3'b010,
        OP_BINOP = 3'b011,
        OP_UNOP  = 3'b100,
        OP_DUP   = 3'b101,
        OP_SWAP  = 3'b110,
        OP_RSVD  = 3'b111
    } stack_op_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } stack_state_t;

endpackage

// File: rtl/stack_ram.sv
// Spill storage for the entries below NOS: one write port and one registered read port.
module stack_ram #(
    parameter int ENTRIES = 14,
    parameter int WIDTH   = 32,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [WIDTH-1:0] rd_data_q;

    // Storage has no reset; the read register only updates when a refill is requested.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/operand_stack.sv
// Operand stack: TOS/NOS live in registers feeding the ALU, deeper entries spill to RAM.
module operand_stack
    import stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = STACK_WIDTH,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clear
);

    localparam int RAM_N = DEPTH - 2;
    localparam int AW    = $clog2(RAM_N);

    stack_state_t     state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ready_q, ready_d;

    logic             ram_wr_en;
    logic             ram_rd_en;
    logic [AW-1:0]    ram_wr_addr;
    logic [AW-1:0]    ram_rd_addr;
    logic [WIDTH-1:0] ram_rd_data;

    stack_op_t        cmd;
    logic             accept;
    logic             cnt_ge1;
    logic             cnt_ge2;
    logic             cnt_ge3;
    logic             is_full;

    assign cmd         = stack_op_t'(op);
    assign accept      = op_valid && ready_q;
    assign cnt_ge1     = (count_q >= CW'(1));
    assign cnt_ge2     = (count_q >= CW'(2));
    assign cnt_ge3     = (count_q >= CW'(3));
    assign is_full     = (count_q == CW'(DEPTH));
    assign ram_wr_addr = AW'(count_q - CW'(2));
    assign ram_rd_addr = AW'(count_q - CW'(3));

    stack_ram #(
        .ENTRIES(RAM_N),
        .WIDTH  (WIDTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_wr_en),
        .wr_addr(ram_wr_addr),
        .wr_data(nos_q),
        .rd_en  (ram_rd_en),
        .rd_addr(ram_rd_addr),
        .rd_data(ram_rd_data)
    );

    // Decode the accepted command; a faulting command only raises its sticky flag.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tos_d     = tos_q;
        nos_d     = nos_q;
        ovf_d     = ovf_q && !err_clear;
        unf_d     = unf_q && !err_clear;
        ram_wr_en = 1'b0;
        ram_rd_en = 1'b0;

        case (state_q)
            ST_REFILL: begin
                nos_d   = ram_rd_data;
                state_d = ST_IDLE;
            end
            default: begin
                if (accept) begin
                    case (cmd)
                        OP_PUSH: begin
                            if (is_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                ram_wr_en = cnt_ge2;
                                nos_d     = tos_q;
                                tos_d     = push_data;
                                count_d   = count_q + CW'(1);
                            end
                        end
                        OP_DUP: begin
                            if (!cnt_ge1) begin
                                unf_d = 1'b1;
                            end else if (is_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                ram_wr_en = cnt_ge2;
                                nos_d     = tos_q;
                                count_d   = count_q + CW'(1);
                            end
                        end
                        OP_POP: begin
                            if (!cnt_ge1) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d   = nos_q;
                                count_d = count_q - CW'(1);
                                if (cnt_ge3) begin
                                    ram_rd_en = 1'b1;
                                    state_d   = ST_REFILL;
                                end
                            end
                        end
                        OP_BINOP: begin
                            if (!cnt_ge2) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d   = alu_result;
                                count_d = count_q - CW'(1);
                                if (cnt_ge3) begin
                                    ram_rd_en = 1'b1;
                                    state_d   = ST_REFILL;
                                end
                            end
                        end
                        OP_UNOP: begin
                            if (!cnt_ge1) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d = alu_result;
                            end
                        end
                        OP_SWAP: begin
                            if (!cnt_ge2) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d = nos_q;
                                nos_d = tos_q;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // Ready is registered so it is stable for the whole cycle the refill is pending.
    assign ready_d = (state_d == ST_IDLE);

    // State, stack registers and sticky flags; reset aborts any refill in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ready_q <= ready_d;
        end
    end

    assign op_ready  = ready_q;
    assign operand_a = nos_q;
    assign operand_b = tos_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
